data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words stored (power of two, 4..1024).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store word, 0 = load word.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port resp_rdata  output  32  load data, valid only while resp_valid=1.
REQ-012 SHALL have port resp_err  output  1  request rejected, valid only while resp_valid=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-014 SHALL accept a request on a cycle with req_valid=1 and req_ready=1, capturing req_write, req_addr and req_wdata into internal registers.
REQ-015 SHALL, on acceptance, go IDLE->WAIT with wait counter loaded to LATENCY-1 when LATENCY>0, or IDLE->RESP when LATENCY=0.
REQ-016 SHALL decrement the counter each WAIT cycle and go WAIT->RESP on the cycle the counter equals 0.
REQ-017 SHALL assert resp_valid=1 for exactly the one RESP cycle, then return to IDLE; total accept-to-resp_valid latency SHALL be LATENCY+1 cycles.
REQ-018 SHALL flag a request as an error when captured addr[1:0]!=0 (misaligned) or addr>=DEPTH*4 (out of range).
REQ-019 SHALL, for an error request, set resp_err=1 and resp_rdata=0 and leave memory unmodified.
REQ-020 SHALL, for a valid store, write the captured data into word addr[log2(DEPTH)+1:2] at the clock edge entering RESP; resp_rdata=0, resp_err=0.
REQ-021 SHALL, for a valid load, drive resp_rdata with that word's contents as of the RESP cycle; resp_err=0.
REQ-022 SHALL ignore req_valid and req_* input changes while not in IDLE; changes after acceptance SHALL NOT affect the transaction.
REQ-023 SHALL provide no response back-pressure; the initiator SHALL sample resp_* during resp_valid.
REQ-024 SHALL drive resp_rdata=0 and resp_err=0 whenever resp_valid=0.
REQ-025 SHALL allow a new acceptance on the first IDLE cycle after RESP, so back-to-back throughput is one request per LATENCY+2 cycles.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, enter IDLE, clear the counter and captured registers, and clear all DEPTH words to 0.
REQ-027 SHALL, after reset, drive req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 SHALL abort any in-flight transaction on reset without writing memory and without a response.

Structure
REQ-029 SHALL place the state encoding (IDLE, WAIT, RESP) and the word width constant (32) in the shared mips_pkg package.
REQ-030 SHALL use one sub-module, word_ram (single synchronous write port, one combinational read port, synchronous clear), for storage; FSM and address checks stay in data_mem_responder.

Verification
REQ-031 SHALL cover: LATENCY=2, store 0xDEADBEEF to 0x10, then load 0x10 -> load resp_valid 3 cycles after acceptance with rdata=0xDEADBEEF, err=0.
REQ-032 SHALL cover: load from 0x12 (misaligned) -> resp_err=1, rdata=0; subsequent load of 0x10 still returns prior value.
REQ-033 SHALL cover: DEPTH=64, store 0x12345678 to 0x100 -> resp_err=1; load 0x0FC returns 0 (no aliasing write).
REQ-034 SHALL cover: LATENCY=0, back-to-back stores to 0x0 and 0x4 with req_valid held high -> responses 1 cycle after each acceptance, req_ready low during RESP, both words written.
REQ-035 SHALL cover: accept store 0xAAAA5555 to 0x8, assert rst during WAIT -> no resp_valid, req_ready=1 after reset, load 0x8 returns 0.
REQ-036 SHALL cover: change req_addr/req_wdata during WAIT -> response and memory reflect the values captured at acceptance.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the data memory responder.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } respState_t;

endpackage

// File: rtl/word_ram.sv
// Word storage: one synchronous write port, one combinational read port,
// and a synchronous clear of every word while rst is high.
module word_ram
  import mips_pkg::*;
#(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WORD_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WORD_W-1:0] rdData
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder with fixed response latency
// and alignment/range checking of byte addresses.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// WAIT  | request captured, counting down the latency
// RESP  | one-cycle response strobe on resp_valid
module data_mem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int               ADDR_W     = $clog2(DEPTH);
  localparam logic [3:0]       CNT_INIT   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(DEPTH * 4);

  respState_t        state;
  logic [3:0]        cnt;
  logic              capWrite;
  logic [WORD_W-1:0] capAddr;
  logic [WORD_W-1:0] capWdata;

  logic              accept;
  logic              goResp;
  logic              curWrite;
  logic              curErr;
  logic              ramWe;
  logic [WORD_W-1:0] curAddr;
  logic [WORD_W-1:0] curWdata;
  logic [WORD_W-1:0] ramRdata;
  logic [ADDR_W-1:0] curIdx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // With LATENCY=0 the transaction enters RESP on the accepting edge,
  // before the capture registers hold it, so decode from the live inputs.
  assign curWrite = (state == IDLE) ? req_write : capWrite;
  assign curAddr  = (state == IDLE) ? req_addr  : capAddr;
  assign curWdata = (state == IDLE) ? req_wdata : capWdata;

  assign goResp = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd0));
  assign curErr = (curAddr[1:0] != 2'b00) || (curAddr >= ADDR_LIMIT);
  assign curIdx = curAddr[ADDR_W+1:2];
  assign ramWe  = goResp && curWrite && !curErr;

  word_ram #(
    .DEPTH(DEPTH)
  ) uRam (
    .clk   (clk),
    .rst   (rst),
    .wrEn  (ramWe),
    .wrAddr(curIdx),
    .wrData(curWdata),
    .rdAddr(curIdx),
    .rdData(ramRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      capWrite   <= 1'b0;
      capAddr    <= '0;
      capWdata   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      if (goResp) begin
        resp_valid <= 1'b1;
        resp_err   <= curErr;
        resp_rdata <= (curWrite || curErr) ? '0 : ramRdata;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            capWrite <= req_write;
            capAddr  <= req_addr;
            capWdata <= req_wdata;
            cnt      <= CNT_INIT;
            state    <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: instance 0 has LATENCY=2, instance 1 has LATENCY=0,
// both DEPTH=64, checked against a word-array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid   [2];
  logic        reqReady   [2];
  logic        reqWrite   [2];
  logic [31:0] reqAddr    [2];
  logic [31:0] reqWdata   [2];
  logic        respValid  [2];
  logic [31:0] respRdata  [2];
  logic        respErr    [2];

  logic [31:0] refMem [2][64];
  int          total = 0;
  int          bad   = 0;
  int          expLat [2] = '{3, 1};

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        expErr;
    logic [31:0] expRd;
  } vec_t;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(64), .LATENCY(2)) uDutA (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .resp_valid(respValid[0]), .resp_rdata(respRdata[0]), .resp_err(respErr[0])
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(0)) uDutB (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .resp_valid(respValid[1]), .resp_rdata(respRdata[1]), .resp_err(respErr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic modelErr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd256);
  endfunction

  task automatic clearModel();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) refMem[s][i] = '0;
  endtask

  // Issues one request, holds req_valid high and scrambles req_* while
  // waiting, and returns the response plus cycles from acceptance.
  task automatic doReq(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("ready_before_req", 32'(reqReady[s]), 32'd1);
    reqValid[s] = 1'b1;
    reqWrite[s] = w;
    reqAddr[s]  = a;
    reqWdata[s] = d;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (respValid[s]) break;
      check("wait_ready", 32'(reqReady[s]), 32'd0);
      check("wait_rdata", respRdata[s], 32'd0);
      check("wait_err", 32'(respErr[s]), 32'd0);
      reqWrite[s] = 1'($urandom_range(0, 1));
      reqAddr[s]  = $urandom();
      reqWdata[s] = $urandom();
    end
    check("resp_timeout", 32'(respValid[s]), 32'd1);
    check("resp_ready", 32'(reqReady[s]), 32'd0);
    rd = respRdata[s];
    er = respErr[s];
    reqValid[s] = 1'b0;
  endtask

  task automatic runTxn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] expRd, rd;
    logic        expErr, er;
    int          lat;
    expErr = modelErr(a);
    expRd  = (w || expErr) ? 32'd0 : refMem[s][a[7:2]];
    doReq(s, w, a, d, rd, er, lat);
    check("txn_lat", 32'(lat), 32'(expLat[s]));
    check("txn_err", 32'(er), 32'(expErr));
    check("txn_rdata", rd, expRd);
    if (w && !expErr) refMem[s][a[7:2]] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [10];
    logic [31:0] rd, a;
    logic        er;
    int          lat, r;

    for (int s = 0; s < 2; s++) begin
      reqValid[s] = 0; reqWrite[s] = 0; reqAddr[s] = 0; reqWdata[s] = 0;
    end
    clearModel();

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h0BAD_F00D};
    vecs[9] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 32'(reqReady[s]), 32'd1);
      check("rst_valid", 32'(respValid[s]), 32'd0);
      check("rst_rdata", respRdata[s], 32'd0);
      check("rst_err", 32'(respErr[s]), 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      doReq(0, vecs[i].w, vecs[i].a, vecs[i].d, rd, er, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].expErr));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
      if (vecs[i].w && !vecs[i].expErr) refMem[0][vecs[i].a[7:2]] = vecs[i].d;
    end

    // Reset while a store to 0x8 sits in WAIT.
    @(negedge clk);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqAddr[0] = 32'h8; reqWdata[0] = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    reqValid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    check("abort_ready", 32'(reqReady[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", 32'(respValid[0]), 32'd0);
      @(negedge clk);
    end
    doReq(0, 1'b0, 32'h8, 32'h0, rd, er, lat);
    check("abort_load8_rdata", rd, 32'd0);
    check("abort_load8_err", 32'(er), 32'd0);
    runTxn(0, 1'b0, 32'h10, 32'h0);

    // LATENCY=0 back-to-back stores with req_valid held high.
    @(negedge clk);
    reqValid[1] = 1'b1; reqWrite[1] = 1'b1; reqAddr[1] = 32'h0; reqWdata[1] = 32'h1111_0000;
    check("b2b_ready0", 32'(reqReady[1]), 32'd1);
    @(negedge clk);
    check("b2b_resp1", 32'(respValid[1]), 32'd1);
    check("b2b_ready1", 32'(reqReady[1]), 32'd0);
    check("b2b_err1", 32'(respErr[1]), 32'd0);
    check("b2b_rdata1", respRdata[1], 32'd0);
    reqAddr[1] = 32'h4; reqWdata[1] = 32'h2222_0004;
    @(negedge clk);
    check("b2b_resp2_idle", 32'(respValid[1]), 32'd0);
    check("b2b_ready2", 32'(reqReady[1]), 32'd1);
    @(negedge clk);
    check("b2b_resp3", 32'(respValid[1]), 32'd1);
    check("b2b_ready3", 32'(reqReady[1]), 32'd0);
    check("b2b_err3", 32'(respErr[1]), 32'd0);
    reqValid[1] = 1'b0;
    @(negedge clk);
    check("b2b_resp4", 32'(respValid[1]), 32'd0);
    doReq(1, 1'b0, 32'h0, 32'h0, rd, er, lat);
    check("b2b_word0", rd, 32'h1111_0000);
    check("b2b_lat_load", 32'(lat), 32'd1);
    doReq(1, 1'b0, 32'h4, 32'h0, rd, er, lat);
    check("b2b_word1", rd, 32'h2222_0004);
    refMem[1][0] = 32'h1111_0000;
    refMem[1][1] = 32'h2222_0004;

    for (int n = 0; n < 240; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = {22'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (r == 7) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (r == 8) a = 32'd256 + 32'($urandom_range(0, 255)) * 4;
      else             a = $urandom();
      runTxn(n % 2, 1'($urandom_range(0, 1)), a, $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
